cover_hit_scheduler: RTL and testbench

COVER_HIT_SCHEDULER -- requirements
Module: cover_hit_scheduler

---
 rtl/cover_pkg.sv | 7 +
 rtl/cover_prio_enc.sv | 26 ++
 rtl/cover_hit_scheduler.sv | 77 +++++++
 tb/tb_cover_hit_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared widths, defaults and the cover index type for the toggle-cover scheduler.
package cover_pkg;
    localparam int COVER_W_DEFAULT = 64;
    localparam int IDX_W           = 64;

    typedef logic [IDX_W-1:0] cover_idx_t;
endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot mask and any-set flag.
// Purely combinational, zero latency, no backpressure.
module cover_prio_enc #(
    parameter int W  = 64,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic [W-1:0]  onehot,
    output logic          any
);

    // Scanning from the top leaves the lowest set bit as the final winner.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign onehot = vec & (~vec + W'(1));
    assign any    = |vec;

endmodule

// File: rtl/cover_hit_scheduler.sv
// Captures first toggle hits per epoch and streams their global cover indices one per cycle.
// Latency: hit in cycle t -> pending at t+1 -> offered at t+2 when the slot is free.
// Backpressure: out_valid/out_index hold while out_ready is low; hits queue in the pending bitmap.
module cover_hit_scheduler
    import cover_pkg::*;
#(
    parameter cover_idx_t COVER_INDEX = '0,
    parameter int         COVER_W     = COVER_W_DEFAULT,
    parameter int         CNT_W       = $clog2(COVER_W) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [COVER_W-1:0] valid,
    output logic               out_valid,
    input  logic               out_ready,
    output cover_idx_t         out_index,
    output logic [CNT_W-1:0]   hit_count,
    output logic               all_covered
);

    localparam int SEL_W = (COVER_W > 1) ? $clog2(COVER_W) : 1;

    logic [COVER_W-1:0] covered;
    logic [COVER_W-1:0] pending;
    logic [COVER_W-1:0] new_hits;
    logic [COVER_W-1:0] load_mask;
    logic [SEL_W-1:0]   sel_idx;
    logic               pend_any;
    logic               load;

    cover_prio_enc #(
        .W  (COVER_W),
        .IW (SEL_W)
    ) u_prio_enc (
        .vec    (pending),
        .idx    (sel_idx),
        .onehot (load_mask),
        .any    (pend_any)
    );

    // Only points not yet seen this epoch count; clear wins over capture.
    assign new_hits = (enable && !clear) ? (valid & ~covered) : '0;
    assign load     = pend_any && (!out_valid || out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            covered   <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            hit_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_index <= COVER_INDEX + cover_idx_t'(sel_idx);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // The output slot is deliberately untouched by clear.
            if (clear) begin
                covered   <= '0;
                pending   <= '0;
                hit_count <= '0;
            end else begin
                covered   <= covered | new_hits;
                pending   <= (pending & ~(load ? load_mask : '0)) | new_hits;
                hit_count <= hit_count + CNT_W'($countones(new_hits));
            end
        end
    end

    assign all_covered = (hit_count == CNT_W'(COVER_W));

endmodule

// File: tb/tb_cover_hit_scheduler.sv
// Bench for cover_hit_scheduler: directed vector table, corner sequences, randomized run vs. a reference model.
module tb_cover_hit_scheduler;
    import cover_pkg::*;

    localparam int         W    = 64;
    localparam cover_idx_t BASE = 64'd100;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] valid = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    cover_idx_t   out_index;
    logic [6:0]   hit_count;
    logic         all_covered;

    int n_checks = 0;
    int n_pass   = 0;

    cover_hit_scheduler #(
        .COVER_INDEX (BASE),
        .COVER_W     (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .valid       (valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .hit_count   (hit_count),
        .all_covered (all_covered)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0]    v;
        bit              en;
        bit              clr;
        bit              rdy;
        bit              eov;
        longint unsigned eidx;
        int              ehc;
    } vec_t;

    vec_t tbl[16];

    // Reference model state: sets of covered / pending points plus the output slot.
    bit              m_cov[W];
    bit              m_pend[W];
    bit              m_ov;
    longint unsigned m_idx;
    int              m_hc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; valid = '0; enable = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic model_clear_epoch();
        for (int i = 0; i < W; i++) begin
            m_cov[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_hc = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        int lo;
        lo = -1;
        if (reset) begin
            model_clear_epoch();
            m_ov  = 1'b0;
            m_idx = 0;
            return;
        end
        if (!m_ov || out_ready) begin
            for (int i = 0; i < W; i++) begin
                if (m_pend[i]) begin
                    lo = i;
                    break;
                end
            end
        end
        if (lo >= 0) begin
            m_pend[lo] = 1'b0;
            m_ov       = 1'b1;
            m_idx      = BASE + 64'(lo);
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (clear) begin
            model_clear_epoch();
        end else if (enable) begin
            for (int i = 0; i < W; i++) begin
                if (valid[i] && !m_cov[i]) begin
                    m_cov[i]  = 1'b1;
                    m_pend[i] = 1'b1;
                    m_hc++;
                end
            end
        end
    endtask

    initial begin
        int cnt;
        longint unsigned last;

        // Directed table: inputs for one cycle, expected outputs after that edge.
        tbl[0]  = '{64'h1, 1, 0, 1, 0, 0,   1};
        tbl[1]  = '{64'h0, 1, 0, 1, 1, 100, 1};
        tbl[2]  = '{64'h0, 1, 0, 1, 0, 0,   1};
        tbl[3]  = '{64'h6, 1, 0, 0, 0, 0,   3};
        tbl[4]  = '{64'h0, 1, 0, 0, 1, 101, 3};
        tbl[5]  = '{64'h0, 1, 0, 0, 1, 101, 3};
        tbl[6]  = '{64'h0, 1, 0, 0, 1, 101, 3};
        tbl[7]  = '{64'h0, 1, 0, 1, 1, 102, 3};
        tbl[8]  = '{64'h0, 1, 0, 1, 0, 0,   3};
        tbl[9]  = '{64'h8, 1, 0, 1, 0, 0,   4};
        tbl[10] = '{64'h0, 1, 0, 1, 1, 103, 4};
        tbl[11] = '{64'h8, 1, 1, 1, 0, 0,   0};
        tbl[12] = '{64'h8, 0, 0, 1, 0, 0,   0};
        tbl[13] = '{64'h8, 1, 0, 1, 0, 0,   1};
        tbl[14] = '{64'h8, 1, 0, 1, 1, 103, 1};
        tbl[15] = '{64'h0, 1, 0, 1, 0, 0,   1};

        do_reset();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_index", out_index, 0);
        chk("reset_hit_count", hit_count, 0);
        chk("reset_all_covered", all_covered, 0);

        for (int k = 0; k < 16; k++) begin
            valid = tbl[k].v; enable = tbl[k].en; clear = tbl[k].clr; out_ready = tbl[k].rdy;
            tick();
            chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].eov);
            if (tbl[k].eov) chk($sformatf("tbl%0d_out_index", k), out_index, tbl[k].eidx);
            chk($sformatf("tbl%0d_hit_count", k), hit_count, longint'(tbl[k].ehc));
        end
        clear = 1'b0;

        // All 64 points in one cycle drain back-to-back.
        do_reset();
        valid = '1; out_ready = 1'b1;
        tick();
        valid = '0;
        chk("burst_first_gap", out_valid, 0);
        for (int k = 0; k < W; k++) begin
            tick();
            chk($sformatf("burst_idx%0d", k), out_valid ? out_index : 64'hFFFF_FFFF_FFFF_FFFF, BASE + 64'(k));
        end
        tick();
        chk("burst_drained", out_valid, 0);
        chk("burst_hit_count", hit_count, 64);
        chk("burst_all_covered", all_covered, 1);

        // Repeated hits on one point emit it exactly once.
        do_reset();
        out_ready = 1'b1;
        cnt = 0; last = 0;
        for (int k = 0; k < 24; k++) begin
            valid = (k < 20 && k % 2 == 0) ? 64'h20 : 64'h0;
            tick();
            if (out_valid) begin
                cnt++;
                last = out_index;
            end
        end
        valid = '0;
        chk("repeat_emissions", longint'(cnt), 1);
        chk("repeat_index", last, 105);
        chk("repeat_hit_count", hit_count, 1);

        // Reset with ten points pending and one offered discards them all.
        do_reset();
        valid = 64'h3FF; out_ready = 1'b0;
        tick();
        valid = '0;
        tick();
        chk("pre_reset_offer", out_valid ? out_index : 0, 100);
        reset = 1'b1;
        tick();
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_hit_count", hit_count, 0);
        reset = 1'b0; out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("no_stale_emission", longint'(cnt), 0);

        // Randomized run against the reference model.
        do_reset();
        model_clear_epoch();
        m_ov = 1'b0; m_idx = 0;
        for (int k = 0; k < 1500; k++) begin
            valid     = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 49) == 0) valid = '1;
            enable    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            reset     = ($urandom_range(0, 199) == 0);
            model_step();
            tick();
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov) chk("rnd_out_index", out_index, m_idx);
            chk("rnd_hit_count", hit_count, longint'(m_hc));
            chk("rnd_all_covered", all_covered, (m_hc == W) ? 1 : 0);
        end
        reset = 1'b0; clear = 1'b0; valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
